eprisc_bus_bridge: RTL

//   Memory-mapped bridge between the epRISC core bus and the 8-lane peripheral bus (oBusMOSI/iBusMISO/oBusClock/oBusSelect).

---
 rtl/eprisc_bus_pkg.sv | 72 +++++++
 rtl/eprisc_bus_divider.sv | 38 +++
 rtl/eprisc_bus_bridge.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/eprisc_bus_pkg.sv
// Shared definitions for the epRISC peripheral bus bridge: register map, CTRL/STATUS layout and FSM encoding.
// Bit indices are little-endian here; the core's [0:31] numbering, where bit 31 is the LSB, maps onto bit 0.
package eprisc_bus_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam logic [1:0] SEL_NONE = 2'h0;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_EXT  = 3;

    // CTRL layout, MSB first: ie_ext is bit 12 and div occupies bits 7:0
    typedef struct packed {
        logic       ie_ext;
        logic       ie_done;
        logic       hold;
        logic [1:0] sel;
        logic [7:0] div;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } bus_state_t;

    // Beat 0 carries the most significant byte in both directions
    function automatic logic [7:0] tx_byte(input logic [31:0] word, input logic [1:0] beat);
        case (beat)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            2'd3:    return word[7:0];
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [31:0] rx_insert(input logic [31:0] word, input logic [1:0] beat,
                                              input logic [7:0] data);
        logic [31:0] result;
        result = word;
        case (beat)
            2'd0:    result[31:24] = data;
            2'd1:    result[23:16] = data;
            2'd2:    result[15:8]  = data;
            2'd3:    result[7:0]   = data;
            default: result        = word;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] status_word(input logic busy, input logic done,
                                                input logic ovr, input logic ext);
        logic [31:0] result;
        result            = 32'd0;
        result[STAT_BUSY] = busy;
        result[STAT_DONE] = done;
        result[STAT_OVR]  = ovr;
        result[STAT_EXT]  = ext;
        return result;
    endfunction

endpackage

// File: rtl/eprisc_bus_divider.sv
// Phase timer for the peripheral clock: a tick comes div+1 clocks after each reload.
// The count is compared before it is incremented, so div=255 never wraps.
module eprisc_bus_divider (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       reload_i,
    input  logic       enable_i,
    input  logic [7:0] div_i,
    output logic       tick_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign tick_o = enable_i && (count_q == div_i);

    // Next count: restart at every phase boundary, otherwise advance while a phase runs
    always_comb begin
        count_d = count_q;
        if (reload_i || tick_o) begin
            count_d = 8'd0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/eprisc_bus_bridge.sv
// Core-bus to 8-lane peripheral-bus bridge. It has a 4-word register window and sends each
// 32-bit word as four byte beats, with a completion or peripheral-request interrupt.
module eprisc_bus_bridge
    import eprisc_bus_pkg::*;
#(
    parameter logic [31:0] pBaseAddress    = 32'h0000_FF00,
    parameter logic [7:0]  pDefaultDivider = 8'd3,
    parameter logic [2:0]  pBeats          = 3'd4
) (
    input  logic        iBoardClock,
    input  logic        iBoardReset,
    input  logic        iCoreStrobe,
    input  logic        iCoreWrite,
    input  logic [31:0] iCoreAddress,
    input  logic [31:0] iCoreData,
    output logic [31:0] oCoreData,
    output logic        oCoreInterrupt,
    output logic        oBusClock,
    output logic [1:0]  oBusSelect,
    output logic [7:0]  oBusMOSI,
    input  logic [7:0]  iBusMISO,
    input  logic        iBusInterrupt
);

    localparam logic [1:0] LAST_BEAT = 2'(pBeats - 3'd1);

    bus_state_t  state_q, state_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
    logic [7:0]  xfer_div_q, xfer_div_d, mosi_q, mosi_d;
    logic [1:0]  xfer_sel_q, xfer_sel_d, beat_q, beat_d, bus_sel_q, bus_sel_d;
    logic [31:0] tx_q, tx_d, rx_q, rx_d, data_q, data_d, rdata_q, rdata_d;
    logic        bus_clk_q, bus_clk_d, irq_q, irq_d, ext_meta_q, ext_q;
    logic        hit_s, rd_s, wr_data_s, rd_data_s, wr_ctrl_s, wr_status_s;
    logic        tick_s, reload_s, count_en_s, done_set_s, ovr_set_s;
    logic [1:0]  reg_s;

    assign hit_s       = iCoreStrobe && (iCoreAddress[31:2] == pBaseAddress[31:2]);
    assign reg_s       = iCoreAddress[1:0];
    assign rd_s        = hit_s && !iCoreWrite;
    assign wr_data_s   = hit_s && iCoreWrite && (reg_s == REG_DATA);
    assign rd_data_s   = rd_s && (reg_s == REG_DATA);
    assign wr_ctrl_s   = hit_s && iCoreWrite && (reg_s == REG_CTRL);
    assign wr_status_s = hit_s && iCoreWrite && (reg_s == REG_STATUS);

    assign reload_s   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign count_en_s = (state_q == ST_LOW) || (state_q == ST_HIGH);

    eprisc_bus_divider u_divider (
        .clk_i    (iBoardClock),
        .rst_i    (iBoardReset),
        .reload_i (reload_s),
        .enable_i (count_en_s),
        .div_i    (xfer_div_q),
        .tick_o   (tick_s)
    );

    // Transfer FSM: next state plus the bus-side datapath it steers
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        beat_d     = beat_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_d     = data_q;
        xfer_div_d = xfer_div_q;
        xfer_sel_d = xfer_sel_q;
        bus_sel_d  = bus_sel_q;
        bus_clk_d  = bus_clk_q;
        mosi_d     = mosi_q;
        done_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_data_s) begin
                    state_d    = ST_LOW;
                    busy_d     = 1'b1;
                    beat_d     = 2'd0;
                    tx_d       = iCoreData;
                    xfer_div_d = ctrl_q.div;
                    xfer_sel_d = ctrl_q.sel;
                    bus_sel_d  = ctrl_q.sel;
                    mosi_d     = tx_byte(iCoreData, 2'd0);
                end else if ((bus_sel_q != SEL_NONE) &&
                             (!ctrl_q.hold || (ctrl_q.sel != xfer_sel_q))) begin
                    // A held select is released once software drops hold or retargets sel
                    bus_sel_d = SEL_NONE;
                end else begin
                    bus_sel_d = bus_sel_q;
                end
            end
            ST_LOW: begin
                if (tick_s) begin
                    state_d   = ST_HIGH;
                    bus_clk_d = 1'b1;
                    rx_d      = rx_insert(rx_q, beat_q, iBusMISO);
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (tick_s) begin
                    bus_clk_d = 1'b0;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOW;
                        beat_d  = beat_q + 2'd1;
                        mosi_d  = tx_byte(tx_q, beat_q + 2'd1);
                    end
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                data_d     = rx_q;
                done_set_s = 1'b1;
                if (!ctrl_q.hold) begin
                    bus_sel_d = SEL_NONE;
                end else begin
                    bus_sel_d = bus_sel_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register file: CTRL, sticky STATUS flags (a set beats a clear), read mux and interrupt
    always_comb begin
        ovr_set_s = wr_data_s && busy_q;
        if (done_set_s) begin
            done_d = 1'b1;
        end else if (rd_data_s || (wr_status_s && iCoreData[STAT_DONE])) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (wr_status_s && iCoreData[STAT_OVR]) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
        if (wr_ctrl_s) begin
            ctrl_d = ctrl_t'(iCoreData[CTRL_W-1:0]);
        end else begin
            ctrl_d = ctrl_q;
        end
        rdata_d = rdata_q;
        if (rd_s) begin
            case (reg_s)
                REG_DATA:   rdata_d = data_q;
                REG_CTRL:   rdata_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
                REG_STATUS: rdata_d = status_word(busy_q, done_q, ovr_q, ext_q);
                REG_RSVD:   rdata_d = 32'd0;
                default:    rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
        irq_d = (done_q && ctrl_q.ie_done) || (ext_q && ctrl_q.ie_ext);
    end

    // FSM state register
    always_ff @(posedge iBoardClock or posedge iBoardReset) begin
        if (iBoardReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, register file and interrupt synchroniser
    always_ff @(posedge iBoardClock or posedge iBoardReset) begin
        if (iBoardReset) begin
            ctrl_q     <= '{ie_ext: 1'b0, ie_done: 1'b0, hold: 1'b0, sel: SEL_NONE, div: pDefaultDivider};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            beat_q     <= 2'd0;
            tx_q       <= 32'd0;
            rx_q       <= 32'd0;
            data_q     <= 32'd0;
            rdata_q    <= 32'd0;
            xfer_div_q <= 8'd0;
            xfer_sel_q <= SEL_NONE;
            bus_sel_q  <= SEL_NONE;
            bus_clk_q  <= 1'b0;
            mosi_q     <= 8'd0;
            irq_q      <= 1'b0;
            ext_meta_q <= 1'b0;
            ext_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            beat_q     <= beat_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            xfer_div_q <= xfer_div_d;
            xfer_sel_q <= xfer_sel_d;
            bus_sel_q  <= bus_sel_d;
            bus_clk_q  <= bus_clk_d;
            mosi_q     <= mosi_d;
            irq_q      <= irq_d;
            ext_meta_q <= iBusInterrupt;
            ext_q      <= ext_meta_q;
        end
    end

    assign oCoreData      = rdata_q;
    assign oCoreInterrupt = irq_q;
    assign oBusClock      = bus_clk_q;
    assign oBusSelect     = bus_sel_q;
    assign oBusMOSI       = mosi_q;

endmodule
